// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module : sprite_pkg
// Desc   : Shared types, constants and ROM addressing for the sprite blitter.
// Rev    : 1.0 - initial release
// ============================================================================
package sprite_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int TRANSPARENT_IDX = 0;
  localparam int DEF_SCREEN_W    = 640;
  localparam int DEF_SCREEN_H    = 480;

  // Frames of one direction are stored back to back, rows within a frame likewise.
  function automatic int unsigned sprite_row_addr(input int unsigned dir,
                                                  input int unsigned frame,
                                                  input int unsigned row,
                                                  input int unsigned n_frames,
                                                  input int unsigned sprite_h);
    return (dir * n_frames + frame) * sprite_h + row;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_recolor.sv
`default_nettype none
// ============================================================================
// Module : sprite_recolor
// Desc   : Pixel write decision (opaque and on-screen) and variant recolour.
// Rev    : 1.0 - initial release
// ============================================================================
module sprite_recolor
  import sprite_pkg::*;
#(
  parameter int IDX_W          = 5,
  parameter int COLOR_W        = 5,
  parameter int VAR_W          = 2,
  parameter int VARIANT_STRIDE = 3,
  parameter int X_W            = 10,
  parameter int Y_W            = 9,
  parameter int SCREEN_W       = DEF_SCREEN_W,
  parameter int SCREEN_H       = DEF_SCREEN_H
) (
  input  logic [IDX_W-1:0]   idx,
  input  logic [VAR_W-1:0]   variant,
  input  logic [X_W:0]       px,
  input  logic [Y_W:0]       py,
  output logic               write_en,
  output logic [COLOR_W-1:0] color
);

  always_comb begin
    write_en = (idx != IDX_W'(TRANSPARENT_IDX)) &&
               (px < (X_W + 1)'(SCREEN_W)) &&
               (py < (Y_W + 1)'(SCREEN_H));
    // Truncating each term to COLOR_W gives the required modulo wrap.
    color    = COLOR_W'(idx) + COLOR_W'(variant) * COLOR_W'(VARIANT_STRIDE);
  end

endmodule
`default_nettype wire

// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module : sprite_blitter
// Desc   : Walks one 16x16 ROM sprite row by row, streaming clipped,
//          recoloured pixel writes under valid/ready backpressure.
// Rev    : 1.0 - initial release
// ============================================================================
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter  int SPRITE_W       = 16,
  parameter  int SPRITE_H       = 16,
  parameter  int N_DIRS         = 4,
  parameter  int N_FRAMES       = 2,
  parameter  int IDX_W          = 5,
  parameter  int COLOR_W        = 5,
  parameter  int N_VARIANTS     = 4,
  parameter  int VARIANT_STRIDE = 3,
  parameter  int SCREEN_W       = DEF_SCREEN_W,
  parameter  int SCREEN_H       = DEF_SCREEN_H,
  parameter  int X_W            = 10,
  parameter  int Y_W            = 9,
  localparam int DIR_W          = (N_DIRS > 1) ? $clog2(N_DIRS) : 1,
  localparam int FRAME_W        = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1,
  localparam int VAR_W          = (N_VARIANTS > 1) ? $clog2(N_VARIANTS) : 1,
  localparam int ADDR_W         = $clog2(N_DIRS * N_FRAMES * SPRITE_H)
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [X_W-1:0]            req_x,
  input  logic [Y_W-1:0]            req_y,
  input  logic [DIR_W-1:0]          req_dir,
  input  logic [FRAME_W-1:0]        req_frame,
  input  logic [VAR_W-1:0]          req_variant,
  input  logic                      req_flip,
  input  logic                      abort,
  output logic                      rom_rd,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [SPRITE_W*IDX_W-1:0] rom_row,
  output logic                      fb_we,
  input  logic                      fb_ready,
  output logic [X_W-1:0]            fb_x,
  output logic [Y_W-1:0]            fb_y,
  output logic [COLOR_W-1:0]        fb_color,
  output logic                      busy,
  output logic                      done
);

  localparam int COL_W = $clog2(SPRITE_W);
  localparam int ROW_W = $clog2(SPRITE_H);

  state_e                    state, next_state;
  logic [X_W-1:0]            pos_x;
  logic [Y_W-1:0]            pos_y;
  logic [DIR_W-1:0]          dir_sel;
  logic [FRAME_W-1:0]        frame_sel;
  logic [VAR_W-1:0]          variant_sel;
  logic                      flip_sel;
  logic [ROW_W-1:0]          row;
  logic [COL_W-1:0]          col;
  logic [SPRITE_W*IDX_W-1:0] row_buf;

  logic [COL_W-1:0]          src_col;
  logic [IDX_W-1:0]          pix_idx;
  logic [X_W:0]              px;
  logic [Y_W:0]              py;
  logic                      wr_en;
  logic                      col_last;
  logic                      row_last;
  logic                      step;

  assign src_col  = flip_sel ? (COL_W'(SPRITE_W - 1) - col) : col;
  assign pix_idx  = row_buf[int'(src_col) * IDX_W +: IDX_W];
  // One extra bit so sprites hanging past the right/bottom edge clip instead of wrapping.
  assign px       = {1'b0, pos_x} + (X_W + 1)'(col);
  assign py       = {1'b0, pos_y} + (Y_W + 1)'(row);
  assign col_last = (col == COL_W'(SPRITE_W - 1));
  assign row_last = (row == ROW_W'(SPRITE_H - 1));
  assign step     = (state == ST_EMIT) && (!wr_en || fb_ready);

  assign rom_addr = ADDR_W'(sprite_row_addr(32'(dir_sel), 32'(frame_sel), 32'(row),
                                            N_FRAMES, SPRITE_H));
  assign fb_x      = px[X_W-1:0];
  assign fb_y      = py[Y_W-1:0];
  assign busy      = (state != ST_IDLE);
  assign req_ready = !busy;

  sprite_recolor #(
    .IDX_W          (IDX_W),
    .COLOR_W        (COLOR_W),
    .VAR_W          (VAR_W),
    .VARIANT_STRIDE (VARIANT_STRIDE),
    .X_W            (X_W),
    .Y_W            (Y_W),
    .SCREEN_W       (SCREEN_W),
    .SCREEN_H       (SCREEN_H)
  ) u_recolor (
    .idx      (pix_idx),
    .variant  (variant_sel),
    .px       (px),
    .py       (py),
    .write_en (wr_en),
    .color    (fb_color)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    rom_rd     = 1'b0;
    fb_we      = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE:  if (req_valid) next_state = ST_FETCH;
      ST_FETCH: begin
        rom_rd     = 1'b1;
        next_state = ST_WAIT;
      end
      ST_WAIT:  next_state = ST_EMIT;
      ST_EMIT: begin
        fb_we = wr_en;
        if (step && col_last) next_state = row_last ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done       = !abort;
        next_state = ST_IDLE;
      end
      default:  next_state = ST_IDLE;
    endcase
    if (abort && state != ST_IDLE) next_state = ST_IDLE;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pos_x       <= '0;
      pos_y       <= '0;
      dir_sel     <= '0;
      frame_sel   <= '0;
      variant_sel <= '0;
      flip_sel    <= 1'b0;
      row         <= '0;
      col         <= '0;
      row_buf     <= '0;
    end else begin
      if (state == ST_IDLE && req_valid) begin
        pos_x       <= req_x;
        pos_y       <= req_y;
        dir_sel     <= req_dir;
        frame_sel   <= req_frame;
        variant_sel <= req_variant;
        flip_sel    <= req_flip;
        row         <= '0;
      end
      if (state == ST_WAIT) begin
        row_buf <= rom_row;
        col     <= '0;
      end
      if (step && !abort) begin
        col <= col + COL_W'(1);
        if (col_last && !row_last) row <= row + ROW_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
